dmem_responder: RTL

- Memory-side responder for the pipeline's data-memory port; it is the other end of the core's load/store request interface.
- Accepts one load/store request per transaction over a valid/ready handshake and applies a programmable access latency.
- Performs byte-lane merge for SB/SH/SW and sign/zero extension for LB/LH/LW/LBU/LHU.
- Returns read data and an error flag over a valid/ready response channel; the core stalls until the response arrives.

---
 rtl/dmem_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the core's load/store port.
//               Valid/ready request and response channels, programmable
//               latency, byte-lane stores and sign/zero-extended loads.
//               `DMEM_RSP_ALIGN_FAULT_EN : misaligned half/word accesses fault
//               (otherwise the low address bits are forced to alignment).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [2:0]       req_funct3,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int         c_aw       = $clog2(DEPTH);
    localparam logic [3:0] c_lat_init = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
    localparam bit         c_zero_lat = (LATENCY == 0);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_cnt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [WIDTH-1:0] r_wdata;
    logic [2:0]       r_funct3;
    logic [WIDTH-1:0] r_rsp_rdata;
    logic             r_rsp_err;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_in_idle;
    logic             w_accept;
    logic             w_commit;
    logic             w_we;
    logic [31:0]      w_addr;
    logic [WIDTH-1:0] w_wdata;
    logic [2:0]       w_funct3;
    logic             w_is_half;
    logic             w_is_word;
    logic             w_f3_bad;
    logic             w_range_bad;
    logic             w_align_bad;
    logic             w_err;
    logic [1:0]       w_off;
    logic [c_aw-1:0]  w_idx;
    logic [WIDTH-1:0] w_rword;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [3:0]       w_be;
    logic [WIDTH-1:0] w_wlane;
    logic [WIDTH-1:0] w_ldata;
    logic [WIDTH-1:0] w_rsp_data;

    assign w_in_idle = (r_state == c_idle);
    assign w_accept  = w_in_idle && req_valid;
    // With zero latency the commit happens on the accepting edge itself, so the
    // operands come straight from the request port instead of the capture regs.
    assign w_commit  = ((r_state == c_wait) && (r_cnt == 4'd0)) || (w_accept && c_zero_lat);

    assign w_we     = w_in_idle ? req_we     : r_we;
    assign w_addr   = w_in_idle ? req_addr   : r_addr;
    assign w_wdata  = w_in_idle ? req_wdata  : r_wdata;
    assign w_funct3 = w_in_idle ? req_funct3 : r_funct3;

    always_comb begin
        w_is_half   = (w_funct3[1:0] == 2'b01);
        w_is_word   = (w_funct3[1:0] == 2'b10);
        w_f3_bad    = w_we ? (w_funct3 > 3'b010)
                           : ((w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11));
        w_range_bad = ({2'b00, w_addr[31:2]} >= 32'(DEPTH));
`ifdef DMEM_RSP_ALIGN_FAULT_EN
        w_align_bad = (w_is_half && w_addr[0]) || (w_is_word && (w_addr[1:0] != 2'b00));
        w_off       = w_addr[1:0];
`else
        w_align_bad = 1'b0;
        w_off       = w_is_word ? 2'b00 : (w_is_half ? {w_addr[1], 1'b0} : w_addr[1:0]);
`endif
        w_err       = w_f3_bad || w_range_bad || w_align_bad;
    end

    assign w_idx   = w_addr[2 +: c_aw];
    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{w_off, 3'b000} +: 8];
    assign w_half  = w_rword[{w_off[1], 4'b0000} +: 16];

    always_comb begin
        w_be    = 4'b0000;
        w_wlane = '0;
        case (w_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wlane = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wlane = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = w_wdata;
            end
        endcase
    end

    always_comb begin
        w_ldata = '0;
        case (w_funct3)
            3'b000:  w_ldata = {{(WIDTH-8){w_byte[7]}}, w_byte};
            3'b001:  w_ldata = {{(WIDTH-16){w_half[15]}}, w_half};
            3'b010:  w_ldata = w_rword;
            3'b100:  w_ldata = {{(WIDTH-8){1'b0}}, w_byte};
            3'b101:  w_ldata = {{(WIDTH-16){1'b0}}, w_half};
            default: w_ldata = '0;
        endcase
        w_rsp_data = (w_we || w_err) ? '0 : w_ldata;
    end

    // Reset has priority over a store committing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: if (req_valid) w_state_nxt = c_zero_lat ? c_resp : c_wait;
            c_wait: if (r_cnt == 4'd0) w_state_nxt = c_resp;
            c_resp: if (rsp_ready) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        req_ready = (r_state == c_idle);
        rsp_valid = (r_state == c_resp);
        rsp_rdata = r_rsp_rdata;
        rsp_err   = r_rsp_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_funct3    <= 3'b000;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_cnt    <= c_lat_init;
            end else if ((r_state == c_wait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rsp_rdata <= w_rsp_data;
                r_rsp_err   <= w_err;
            end else if ((r_state == c_resp) && rsp_ready) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
